alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu` datapath instance between NUM_REQ independent requesters, e.g. the execute stage and the branch/compare unit.
- Per requester: valid/ready request channel and valid/ready response channel.
- Arbitrates, registers the winning operands, drives the ALU, registers the result and returns it to the granted requester.
- Sits in the core between requesting pipeline stages and the single ALU instance; the ALU is external and wired to the alu_* ports.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), grant index width; derived, not overridden.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester request accepted (one-hot or zero)
- req_op  input  NUM_REQ x alu_op_t  per-requester operation, packed, requester i at slice i
- req_lhs  input  NUM_REQ x 32  per-requester left operand, packed
- req_rhs  input  NUM_REQ x 32  per-requester right operand, packed
- resp_valid  output  NUM_REQ  result valid for requester i (one-hot or zero)
- resp_ready  input  NUM_REQ  requester i accepts result
- resp_data  output  32  result word, shared, meaningful only when resp_valid!=0
- alu_op  output  alu_op_t  to ALU
- alu_lhs  output  32  to ALU
- alu_rhs  output  32  to ALU
- alu_out  input  32  from ALU, combinational

Behaviour:
- Asynchronous reset (rst_n low), takes effect immediately:
  - state=IDLE, req_ready=0, resp_valid=0, resp_data=0.
  - alu_op=ALU_OP_ZERO, alu_lhs=0, alu_rhs=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally from req_valid and the pointer.
  - req_ready[g]=1 only for the granted g; all others are 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
  - On handshake (req_valid[g]&&req_ready[g]): latch op/lhs/rhs of g into alu_op/alu_lhs/alu_rhs registers, latch g into owner, go to EXEC.
  - With no valid request: stay in IDLE; ALU operand registers hold their last value.
- EXEC (exactly 1 cycle): resp_data<=alu_out, resp_valid<=onehot(owner), go to RESP.
- RESP:
  - Hold resp_valid and resp_data stable until resp_ready[owner]=1.
  - On that handshake: clear resp_valid, go to IDLE.
  - resp_ready of non-owners is ignored.
- Latency:
  - Request accepted in cycle N; resp_valid high from cycle N+2.
  - Minimum issue interval 3 cycles: no acceptance while in EXEC or RESP, and none in the cycle the response handshakes.
- Round-robin pointer:
  - On grant to g, pointer <= (g+1) mod NUM_REQ.
  - Search order: pointer, pointer+1, ... with wrap-around.
  - Pointer updates only on an accepted request.
- Boundaries:
  - All requesters valid simultaneously: exactly one grant, no starvation. Each requester is served within NUM_REQ grants.
  - Requester deasserts req_valid before grant: legal; no state change.
  - Requester holding resp_ready=1 continuously: response is consumed in the first RESP cycle.
  - Requester never asserting resp_ready: arbiter stalls in RESP indefinitely. No timeout.
  - Reset asserted mid-EXEC/RESP: the in-flight operation is discarded, no response issued, outputs go to reset values.
- Arithmetic: the ALU computes; no width conversion. Operands pass through unmodified at 32 bits.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and the pointer logic is removed. Starvation of higher indices is permitted.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Single request, basic path:
  - Stimulus: reset, then req 0 valid, op=ALU_OP_ADD, lhs=5, rhs=7, resp_ready[0]=1.
  - Response: req_ready[0]=1 in cycle N; resp_valid=2'b01 with resp_data=12 in cycle N+2; IDLE in N+3.
- Round-robin under contention:
  - Stimulus: both requesters valid continuously; req0 ALU_OP_SUB 10,3; req1 ALU_OP_XOR 0xF0,0x0F; resp_ready=all ones.
  - Response: grants alternate 0,1,0,1; results 7 and 0xFF; each grant 3 cycles apart.
- Response back-pressure:
  - Stimulus: req1 ALU_OP_SLT lhs=-1, rhs=1; resp_ready[1] held low for 5 cycles.
  - Response: resp_valid=2'b10 and resp_data=1 stable for all 5 cycles. req0 held valid is not granted until the cycle after resp handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during EXEC of req0 ALU_OP_SRA 0x80000000,4.
  - Response: resp_valid=0 immediately; no response after reset release; next grant goes to requester 0.
- Late arrival and stable pointer:
  - Stimulus: req1 only valid, ALU_OP_SEQ 42,42; then req0 valid one cycle after req1 grant.
  - Response: req1 gets result 1; req0 is granted in the first IDLE cycle after; pointer unchanged while idle.
- Fixed priority (build with ALU_ARB_FIXED_PRIO_EN):
  - Stimulus: both valid continuously.
  - Response: requester 0 granted every time; requester 1 never granted.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// =============================================================================
// alu_arbiter : shares one external ALU between NUM_REQ valid/ready requesters.
// Optional macro ALU_ARB_FIXED_PRIO_EN: lowest-index requester always wins.
// Revision: 1.0
// =============================================================================

package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ZERO = 4'd0,
    ALU_OP_ADD  = 4'd1,
    ALU_OP_SUB  = 4'd2,
    ALU_OP_AND  = 4'd3,
    ALU_OP_OR   = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SLL  = 4'd6,
    ALU_OP_SRL  = 4'd7,
    ALU_OP_SRA  = 4'd8,
    ALU_OP_SLT  = 4'd9,
    ALU_OP_SLTU = 4'd10,
    ALU_OP_SEQ  = 4'd11
  } alu_op_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic    [NUM_REQ-1:0]        req_valid,
  output logic    [NUM_REQ-1:0]        req_ready,
  input  alu_op_t [NUM_REQ-1:0]        req_op,
  input  logic    [NUM_REQ-1:0][31:0]  req_lhs,
  input  logic    [NUM_REQ-1:0][31:0]  req_rhs,
  output logic    [NUM_REQ-1:0]        resp_valid,
  input  logic    [NUM_REQ-1:0]        resp_ready,
  output logic    [31:0]               resp_data,
  output alu_op_t                      alu_op,
  output logic    [31:0]               alu_lhs,
  output logic    [31:0]               alu_rhs,
  input  logic    [31:0]               alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant;
  logic               grant_ok;
  logic [IDX_W-1:0]   search_base;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic               req_hs;
  logic               resp_hs;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    return sum[IDX_W-1:0];
  endfunction

  // Walk the ring from the farthest offset back to base so the closest valid wins.
  function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = wrap_add(base, IDX_W'(k));
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (req_hs) begin
      ptr <= wrap_add(grant, IDX_W'(1));
    end
  end

  assign search_base = ptr;
`endif

  assign {grant_ok, grant} = pick(req_valid, search_base);
  assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign req_hs    = (state == IDLE) && grant_ok;
  assign resp_hs   = (state == RESP) && resp_ready[owner];
  assign req_ready = req_hs ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      alu_op     <= ALU_OP_ZERO;
      alu_lhs    <= '0;
      alu_rhs    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      if (req_hs) begin
        alu_op  <= req_op[grant];
        alu_lhs <= req_lhs[grant];
        alu_rhs <= req_rhs[grant];
        owner   <= grant;
      end
      if (state == EXEC) begin
        resp_data  <= alu_out;
        resp_valid <= owner_oh;
      end else if (resp_hs) begin
        resp_valid <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter : vector table, multi-cycle corner sequences and a randomized
// scoreboard against a transaction-level model of the arbiter.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic    [N-1:0]       req_valid;
  logic    [N-1:0]       req_ready;
  alu_op_t [N-1:0]       req_op;
  logic    [N-1:0][31:0] req_lhs;
  logic    [N-1:0][31:0] req_rhs;
  logic    [N-1:0]       resp_valid;
  logic    [N-1:0]       resp_ready;
  logic    [31:0]        resp_data;
  alu_op_t               alu_op;
  logic    [31:0]        alu_lhs;
  logic    [31:0]        alu_rhs;
  logic    [31:0]        alu_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_lhs   (req_lhs),
    .req_rhs   (req_rhs),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .alu_op    (alu_op),
    .alu_lhs   (alu_lhs),
    .alu_rhs   (alu_rhs),
    .alu_out   (alu_out)
  );

  // Behavioural ALU standing in for the external datapath.
  function automatic logic [31:0] alu_fn(input alu_op_t op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUB:  return a - b;
      ALU_OP_AND:  return a & b;
      ALU_OP_OR:   return a | b;
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_SLL:  return a << b[4:0];
      ALU_OP_SRL:  return a >> b[4:0];
      ALU_OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: return {31'd0, a < b};
      ALU_OP_SEQ:  return {31'd0, a == b};
      default:     return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_lhs, alu_rhs);

  typedef struct {
    int          idx;
    alu_op_t     op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i]  = op;
    req_lhs[i] = a;
    req_rhs[i] = b;
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = '0;
    rst_n      = 1'b0;
    #2;
    chk("rst_req_ready",  32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  resp_data, 32'd0);
    chk("rst_alu_op",     32'(alu_op), 32'(ALU_OP_ZERO));
    chk("rst_alu_lhs",    alu_lhs, 32'd0);
    chk("rst_alu_rhs",    alu_rhs, 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // Single transaction with resp_ready held high: grant N, response N+2, idle N+3.
  task automatic run_single(input vec_t v);
    set_req(v.idx, v.op, v.lhs, v.rhs);
    req_valid  = oh(v.idx);
    resp_ready = '1;
    smp();
    chk("vec_grant", 32'(req_ready), 32'(oh(v.idx)));
    cyc();
    req_valid = '0;
    smp();
    chk("vec_exec_quiet", 32'(resp_valid), 32'd0);
    cyc();
    smp();
    chk("vec_resp_valid", 32'(resp_valid), 32'(oh(v.idx)));
    chk("vec_resp_data",  resp_data, v.res);
    cyc();
    smp();
    chk("vec_done", 32'(resp_valid), 32'd0);
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    int          exp_seq[4];
    logic [31:0] exp_res[N];
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int          ng, nr, last_c, w, j;
    int          m_ptr, m_owner, m_age;
    bit          m_busy;
    logic [31:0] m_res;

    tbl[0] = '{0, ALU_OP_ADD,  32'd5,          32'd7,  32'd12};
    tbl[1] = '{1, ALU_OP_SUB,  32'd10,         32'd3,  32'd7};
    tbl[2] = '{0, ALU_OP_XOR,  32'h0000_00F0,  32'h0F, 32'h0000_00FF};
    tbl[3] = '{1, ALU_OP_SLT,  32'hFFFF_FFFF,  32'd1,  32'd1};
    tbl[4] = '{0, ALU_OP_SRA,  32'h8000_0000,  32'd4,  32'hF800_0000};
    tbl[5] = '{1, ALU_OP_SEQ,  32'd42,         32'd42, 32'd1};
    tbl[6] = '{0, ALU_OP_SLTU, 32'hFFFF_FFFF,  32'd1,  32'd0};
    tbl[7] = '{1, ALU_OP_SLL,  32'd1,          32'd31, 32'h8000_0000};

`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    exp_res[0] = 32'd7;
    exp_res[1] = 32'h0000_00FF;

    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < N; i++) set_req(i, ALU_OP_ZERO, 32'd0, 32'd0);
    #2;
    do_reset();

    for (int i = 0; i < 8; i++) run_single(tbl[i]);

    // Contention: both requesters valid continuously.
    do_reset();
    set_req(0, ALU_OP_SUB, 32'd10, 32'd3);
    set_req(1, ALU_OP_XOR, 32'h0000_00F0, 32'h0000_000F);
    resp_ready = '1;
    req_valid  = '1;
    ng = 0; nr = 0; last_c = 0;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("rr_grant", 32'(req_ready), 32'(oh(exp_seq[ng % 4])));
        if (ng > 0) chk("rr_spacing", 32'(c - last_c), 32'd3);
        last_c = c;
        ng++;
      end
      if (resp_valid != '0) begin
        chk("rr_resp_valid", 32'(resp_valid), 32'(oh(exp_seq[nr % 4])));
        chk("rr_resp_data", resp_data, exp_res[exp_seq[nr % 4]]);
        nr++;
      end
      cyc();
    end
    req_valid = '0;
    chk("rr_grant_count", 32'(ng), 32'd4);
    chk("rr_resp_count",  32'(nr), 32'd4);

    // Back-pressure: requester 1 stalls its response, requester 0 waits.
    set_req(1, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
    req_valid  = 2'b10;
    resp_ready = 2'b01;
    smp();
    chk("bp_grant1", 32'(req_ready), 32'b10);
    cyc();
    set_req(0, ALU_OP_ADD, 32'd1, 32'd2);
    req_valid = 2'b01;
    smp();
    chk("bp_exec_blocked", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      smp();
      chk("bp_hold_valid", 32'(resp_valid), 32'b10);
      chk("bp_hold_data",  resp_data, 32'd1);
      chk("bp_hold_block", 32'(req_ready), 32'd0);
    end
    cyc();
    resp_ready = 2'b10;
    smp();
    chk("bp_hs_valid", 32'(resp_valid), 32'b10);
    chk("bp_hs_block", 32'(req_ready), 32'd0);
    cyc();
    resp_ready = 2'b11;
    smp();
    chk("bp_after_valid", 32'(resp_valid), 32'd0);
    chk("bp_after_grant0", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    cyc();
    smp();
    chk("bp_r0_valid", 32'(resp_valid), 32'b01);
    chk("bp_r0_data",  resp_data, 32'd3);
    cyc();

    // Reset in the middle of EXEC.
    set_req(0, ALU_OP_SRA, 32'h8000_0000, 32'd4);
    req_valid = 2'b01;
    smp();
    chk("mr_grant0", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_resp_valid", 32'(resp_valid), 32'd0);
    chk("mr_resp_data",  resp_data, 32'd0);
    chk("mr_alu_op",     32'(alu_op), 32'(ALU_OP_ZERO));
    chk("mr_alu_lhs",    alu_lhs, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      smp();
      chk("mr_no_resp", 32'(resp_valid), 32'd0);
    end
    cyc();
    set_req(1, ALU_OP_ADD, 32'd9, 32'd9);
    req_valid = 2'b11;
    smp();
    chk("mr_next_grant0", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    cyc();
    smp();
    chk("mr_fresh_data", resp_data, 32'hF800_0000);
    cyc();

    // Late arrival of requester 0, then pointer stability across idle cycles.
    set_req(1, ALU_OP_SEQ, 32'd42, 32'd42);
    req_valid = 2'b10;
    smp();
    chk("la_grant1", 32'(req_ready), 32'b10);
    cyc();
    set_req(0, ALU_OP_ADD, 32'd3, 32'd4);
    req_valid = 2'b01;
    smp();
    chk("la_exec_blocked", 32'(req_ready), 32'd0);
    cyc();
    smp();
    chk("la_r1_valid", 32'(resp_valid), 32'b10);
    chk("la_r1_data",  resp_data, 32'd1);
    cyc();
    smp();
    chk("la_grant0", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    cyc();
    smp();
    chk("la_r0_data", resp_data, 32'd7);
    cyc();
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("la_idle", 32'(req_ready), 32'd0);
      cyc();
    end
    req_valid = 2'b11;
    smp();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("la_ptr_hold", 32'(req_ready), 32'b01);
`else
    chk("la_ptr_hold", 32'(req_ready), 32'b10);
`endif
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_age = 0; m_res = '0;
    for (int t = 0; t < 1500; t++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, alu_op_t'(4'($urandom_range(0, 11))), rand_word(), rand_word());
      resp_ready = N'($urandom);
      smp();
      w = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      exp_ready = (w >= 0) ? oh(w) : '0;
      exp_rv    = (m_busy && m_age >= 1) ? oh(m_owner) : '0;
      chk("rnd_req_ready",  32'(req_ready),  32'(exp_ready));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv != '0) chk("rnd_resp_data", resp_data, m_res);
      if (m_busy) begin
        if (m_age >= 1 && resp_ready[m_owner]) m_busy = 1'b0;
        else m_age++;
      end else if (w >= 0) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = w;
        m_res   = alu_fn(req_op[w], req_lhs[w], req_rhs[w]);
`ifdef ALU_ARB_FIXED_PRIO_EN
        m_ptr   = 0;
`else
        m_ptr   = (w + 1) % N;
`endif
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
